// File: rtl/tawas_axi_pkg.sv
// Shared response codes and FSM state encoding for the tawas AXI RAM slave.
package tawas_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_RD_ADDR,
    S_RD_DATA
  } state_e;

endpackage

// File: rtl/tawas_axi_ram_array.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read port.
module tawas_axi_ram_array #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 we_i,
  input  logic [7:0]           be_i,
  input  logic [63:0]          wdata_i,
  input  logic                 re_i,
  output logic [63:0]          rdata_o
);

  logic [63:0] mem [2**ADDR_BITS];
  logic [63:0] rdata_q;

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tawas_axi_ram.sv
// AXI3-subset INCR-only RAM slave, one transaction in flight.
// Optional: define TAWAS_AXI_RAM_ERR_EN to reject addresses above the RAM with SLVERR.
module tawas_axi_ram
  import tawas_axi_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  AWID,
  input  logic [31:0] AWADDR,
  input  logic [3:0]  AWLEN,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [63:0] WDATA,
  input  logic [7:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BID,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [1:0]  ARID,
  input  logic [31:0] ARADDR,
  input  logic [3:0]  ARLEN,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [1:0]  RID,
  output logic [63:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY
);

  state_e               state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [3:0]           cnt_q;
  logic                 last_wr_q;
  logic                 err_q;
  logic [1:0]           bid_q, bresp_q, rid_q, rresp_q;

  logic        idle, grant_wr, aw_hs, ar_hs;
  logic        aw_err, ar_err;
  logic        ram_we, ram_re;
  logic [63:0] ram_rdata;
  logic        unused_addr;

`ifdef TAWAS_AXI_RAM_ERR_EN
  assign aw_err = |AWADDR[31:ADDR_BITS+3];
  assign ar_err = |ARADDR[31:ADDR_BITS+3];
  assign unused_addr = ^{AWADDR[2:0], ARADDR[2:0]};
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
  assign unused_addr = ^{AWADDR[31:ADDR_BITS+3], ARADDR[31:ADDR_BITS+3],
                         AWADDR[2:0], ARADDR[2:0]};
`endif

  // On a tie the grant alternates against the last winner; last_wr_q=0 after reset favours writes.
  always_comb begin
    idle     = (state_q == S_IDLE) && !RST;
    grant_wr = AWVALID && (!ARVALID || !last_wr_q);
    AWREADY  = idle && grant_wr;
    ARREADY  = idle && ARVALID && !grant_wr;
    aw_hs    = AWVALID && AWREADY;
    ar_hs    = ARVALID && ARREADY;
    ram_we   = (state_q == S_WR) && WVALID && !err_q && !RST;
    ram_re   = (state_q == S_RD_ADDR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
      err_q     <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (aw_hs) begin
            bid_q     <= AWID;
            addr_q    <= AWADDR[ADDR_BITS+2:3];
            cnt_q     <= AWLEN;
            last_wr_q <= 1'b1;
            err_q     <= aw_err;
            bresp_q   <= aw_err ? RESP_SLVERR : RESP_OKAY;
            state_q   <= S_WR;
          end else if (ar_hs) begin
            rid_q     <= ARID;
            addr_q    <= ARADDR[ADDR_BITS+2:3];
            cnt_q     <= ARLEN;
            last_wr_q <= 1'b0;
            err_q     <= ar_err;
            rresp_q   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            state_q   <= S_RD_ADDR;
          end
        end
        S_WR: begin
          if (WVALID) begin
            addr_q <= addr_q + ADDR_BITS'(1);
            if (cnt_q == 4'd0) state_q <= S_WRESP;
            else               cnt_q   <= cnt_q - 4'd1;
          end
        end
        S_WRESP: begin
          if (BREADY) state_q <= S_IDLE;
        end
        S_RD_ADDR: state_q <= S_RD_DATA;
        S_RD_DATA: begin
          if (RREADY) begin
            if (cnt_q == 4'd0) begin
              state_q <= S_IDLE;
            end else begin
              addr_q  <= addr_q + ADDR_BITS'(1);
              cnt_q   <= cnt_q - 4'd1;
              state_q <= S_RD_ADDR;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  tawas_axi_ram_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk_i  (CLK),
    .rst_i  (RST),
    .addr_i (addr_q),
    .we_i   (ram_we),
    .be_i   (WSTRB),
    .wdata_i(WDATA),
    .re_i   (ram_re),
    .rdata_o(ram_rdata)
  );

  assign WREADY = (state_q == S_WR);
  assign BVALID = (state_q == S_WRESP);
  assign BID    = bid_q;
  assign BRESP  = bresp_q;
  assign RVALID = (state_q == S_RD_DATA);
  assign RLAST  = RVALID && (cnt_q == 4'd0);
  assign RID    = rid_q;
  assign RRESP  = rresp_q;
  assign RDATA  = err_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_tawas_axi_ram.sv
// Directed bench for tawas_axi_ram; inputs driven and outputs sampled on the falling edge.
module tb_tawas_axi_ram;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic [1:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] wr_q  [16];
  logic [63:0] exp_q [16];

  always #5 CLK = ~CLK;

  tawas_axi_ram #(.ADDR_BITS(10)) dut (
    .CLK(CLK), .RST(RST),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called on a falling edge; burst data comes from wr_q.
  task automatic axi_wr(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [7:0] strb, input logic [1:0] exp_resp);
    int t;
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    #1;
    t = 0;
    while (AWREADY !== 1'b1 && t < 20) begin @(negedge CLK); t++; end
    if (t >= 20) begin chk("aw_timeout", 64'd0, 64'd1); AWVALID = 1'b0; return; end
    @(negedge CLK);
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = wr_q[b]; WSTRB = strb; WVALID = 1'b1;
      t = 0;
      while (WREADY !== 1'b1 && t < 20) begin @(negedge CLK); t++; end
      if (t >= 20) begin chk("w_timeout", 64'd0, 64'd1); WVALID = 1'b0; return; end
      @(negedge CLK);
    end
    WVALID = 1'b0;
    t = 0;
    while (BVALID !== 1'b1 && t < 20) begin @(negedge CLK); t++; end
    if (t >= 20) begin chk("b_timeout", 64'd0, 64'd1); return; end
    chk("bid", 64'(BID), 64'(id));
    chk("bresp", 64'(BRESP), 64'(exp_resp));
    BREADY = 1'b1;
    @(negedge CLK);
    BREADY = 1'b0;
  endtask

  // Called on a falling edge; expected beats come from exp_q.
  task automatic axi_rd(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] exp_resp);
    int t;
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    #1;
    t = 0;
    while (ARREADY !== 1'b1 && t < 20) begin @(negedge CLK); t++; end
    if (t >= 20) begin chk("ar_timeout", 64'd0, 64'd1); ARVALID = 1'b0; return; end
    @(negedge CLK);
    ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      t = 0;
      while (RVALID !== 1'b1 && t < 20) begin @(negedge CLK); t++; end
      if (t >= 20) begin chk("r_timeout", 64'd0, 64'd1); return; end
      if (b == 0) chk("r_latency", 64'(t), 64'd1);
      chk("rdata", RDATA, exp_q[b]);
      chk("rlast", 64'(RLAST), 64'(b == int'(len)));
      chk("rid", 64'(RID), 64'(id));
      chk("rresp", 64'(RRESP), 64'(exp_resp));
      RREADY = 1'b1;
      @(negedge CLK);
      RREADY = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(negedge CLK);

    // Both address channels valid straight out of reset.
    AWID = 2'd3; AWADDR = 32'h20; AWLEN = 4'd0; AWVALID = 1'b1;
    ARID = 2'd1; ARADDR = 32'h20; ARLEN = 4'd0; ARVALID = 1'b1;
    #1;
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_wready",  64'(WREADY),  64'd0);
    chk("rst_bvalid",  64'(BVALID),  64'd0);
    chk("rst_rvalid",  64'(RVALID),  64'd0);
    chk("rst_rlast",   64'(RLAST),   64'd0);
    chk("rst_bid_bresp", 64'({BID, BRESP}), 64'd0);
    chk("rst_rid_rresp", 64'({RID, RRESP}), 64'd0);
    chk("rst_rdata",   RDATA, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("tie_awready", 64'(AWREADY), 64'd1);
    chk("tie_arready", 64'(ARREADY), 64'd0);
    @(negedge CLK);
    AWVALID = 1'b0;
    #1;
    chk("wr_wready", 64'(WREADY), 64'd1);
    chk("wr_arready_blocked", 64'(ARREADY), 64'd0);
    WDATA = 64'hA5A5_5A5A_0F0F_F0F0; WSTRB = 8'hFF; WVALID = 1'b1;
    @(negedge CLK);
    WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bstall_bvalid", 64'(BVALID), 64'd1);
      chk("bstall_bid", 64'(BID), 64'd3);
      chk("bstall_bresp", 64'(BRESP), 64'd0);
      @(negedge CLK);
    end
    BREADY = 1'b1;
    @(negedge CLK);
    BREADY = 1'b0;
    #1;
    chk("tie_read_next", 64'(ARREADY), 64'd1);
    @(negedge CLK);
    ARVALID = 1'b0;
    chk("rdaddr_rvalid", 64'(RVALID), 64'd0);
    @(negedge CLK);
    chk("tie_rvalid", 64'(RVALID), 64'd1);
    chk("tie_rdata", RDATA, 64'hA5A5_5A5A_0F0F_F0F0);
    chk("tie_rid", 64'(RID), 64'd1);
    chk("tie_rlast", 64'(RLAST), 64'd1);
    RREADY = 1'b1;
    @(negedge CLK);
    RREADY = 1'b0;

    // Single-beat write/read round trip.
    wr_q[0] = 64'h1122_3344_5566_7788;
    axi_wr(2'd1, 32'h10, 4'd0, 8'hFF, 2'b00);
    exp_q[0] = 64'h1122_3344_5566_7788;
    axi_rd(2'd2, 32'h10, 4'd0, 2'b00);

    // Full 16-beat burst, data = beat index.
    for (int i = 0; i < 16; i++) wr_q[i] = 64'(i);
    axi_wr(2'd0, 32'h0, 4'd15, 8'hFF, 2'b00);
    for (int i = 0; i < 16; i++) exp_q[i] = 64'(i);
    axi_rd(2'd3, 32'h0, 4'd15, 2'b00);

    // Partial strobe over all-ones.
    wr_q[0] = '1;
    axi_wr(2'd2, 32'h40, 4'd0, 8'hFF, 2'b00);
    wr_q[0] = '0;
    axi_wr(2'd2, 32'h47, 4'd0, 8'h0F, 2'b00);
    exp_q[0] = 64'hFFFF_FFFF_0000_0000;
    axi_rd(2'd1, 32'h40, 4'd0, 2'b00);

    // Burst crossing the top of the RAM wraps to word 0.
    wr_q[0] = 64'hAAAA_0000_0000_AAAA;
    wr_q[1] = 64'hBBBB_0000_0000_BBBB;
    axi_wr(2'd0, 32'h1FF8, 4'd1, 8'hFF, 2'b00);
    exp_q[0] = 64'hAAAA_0000_0000_AAAA;
    exp_q[1] = 64'hBBBB_0000_0000_BBBB;
    axi_rd(2'd0, 32'h1FF8, 4'd1, 2'b00);
    exp_q[0] = 64'hBBBB_0000_0000_BBBB;
    axi_rd(2'd0, 32'h0, 4'd0, 2'b00);

    // Reset in the middle of a 4-beat read.
    ARID = 2'd2; ARADDR = 32'h40; ARLEN = 4'd3; ARVALID = 1'b1;
    #1;
    chk("mid_arready", 64'(ARREADY), 64'd1);
    @(negedge CLK);
    ARVALID = 1'b0;
    @(negedge CLK);
    chk("mid_rvalid", 64'(RVALID), 64'd1);
    chk("mid_rdata", RDATA, 64'hFFFF_FFFF_0000_0000);
    chk("mid_rlast", 64'(RLAST), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_rvalid", 64'(RVALID), 64'd0);
    chk("abort_rlast", 64'(RLAST), 64'd0);
    chk("abort_rdata", RDATA, 64'd0);
    chk("abort_rid", 64'(RID), 64'd0);
    RST = 1'b0;
    ARVALID = 1'b1;
    #1;
    chk("abort_idle", 64'(ARREADY), 64'd1);
    ARVALID = 1'b0;
    exp_q[0] = 64'hFFFF_FFFF_0000_0000;
    axi_rd(2'd1, 32'h40, 4'd0, 2'b00);

`ifdef TAWAS_AXI_RAM_ERR_EN
    wr_q[0] = 64'h7777_7777_7777_7777;
    axi_wr(2'd1, 32'h8000_0048, 4'd0, 8'hFF, 2'b10);
    exp_q[0] = 64'd0;
    axi_rd(2'd2, 32'h8000_0048, 4'd0, 2'b10);
    exp_q[0] = 64'd9;
    axi_rd(2'd2, 32'h48, 4'd0, 2'b00);
`else
    wr_q[0] = 64'h7777_7777_7777_7777;
    axi_wr(2'd1, 32'h8000_0048, 4'd0, 8'hFF, 2'b00);
    exp_q[0] = 64'h7777_7777_7777_7777;
    axi_rd(2'd2, 32'h48, 4'd0, 2'b00);
`endif

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tawas_axi_ram.md
TAWAS_AXI_RAM -- requirements
Module: tawas_axi_ram
Interface
REQ-001 ADDR_BITS, default 10, SHALL set RAM depth to 2^ADDR_BITS 64-bit words (8 KB at default).
REQ-002 CLK  in  1  sole clock; all logic on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 AWID  in  2  write ID.
REQ-005 AWADDR  in  32  write byte address; bits [2:0] ignored.
REQ-006 AWLEN  in  4  write beats minus 1.
REQ-007 AWVALID  in  1  write address valid.
REQ-008 AWREADY  out  1  write address accept.
REQ-009 WDATA  in  64  write data.
REQ-010 WSTRB  in  8  byte enables; bit n gates WDATA[8n+7:8n].
REQ-011 WVALID  in  1  write data valid.
REQ-012 WREADY  out  1  write data accept.
REQ-013 BID  out  2  response ID (latched AWID).
REQ-014 BRESP  out  2  write response.
REQ-015 BVALID  out  1  write response valid.
REQ-016 BREADY  in  1  write response accept.
REQ-017 ARID  in  2  read ID.
REQ-018 ARADDR  in  32  read byte address; bits [2:0] ignored.
REQ-019 ARLEN  in  4  read beats minus 1.
REQ-020 ARVALID  in  1  read address valid.
REQ-021 ARREADY  out  1  read address accept.
REQ-022 RID  out  2  read ID (latched ARID).
REQ-023 RDATA  out  64  read data.
REQ-024 RRESP  out  2  read response.
REQ-025 RLAST  out  1  final read beat.
REQ-026 RVALID  out  1  read data valid.
REQ-027 RREADY  in  1  read data accept.
REQ-028 AxSIZE/AxBURST/AxLOCK/AxCACHE/AxPROT/WID/WLAST SHALL NOT be ports: bursts are always INCR of 64-bit beats, and the beat count alone ends a write.
Function
REQ-029 FSM states: IDLE, WR, WRESP, RD_ADDR, RD_DATA; exactly one transaction in flight, single-port RAM.
REQ-030 IDLE: AWREADY = AWVALID granted, ARREADY = ARVALID granted (combinational from VALID is permitted); both valid -> grant the opposite of last_wr, so writes win the first tie after reset.
REQ-031 AW handshake -> latch ID, word address, beat counter = AWLEN, set last_wr=1, go to WR; WREADY=1 in WR.
REQ-032 WR: each W handshake writes WSTRB-enabled bytes in that cycle, increments word address modulo 2^ADDR_BITS, decrements counter; counter 0 at handshake -> WRESP.
REQ-033 WRESP: BVALID=1 held with stable BID/BRESP until BREADY, then IDLE.
REQ-034 AR handshake -> latch ID/address/ARLEN, last_wr=0, RD_ADDR; RD_ADDR issues RAM read -> RD_DATA next cycle with RVALID=1 (first RVALID 2 cycles after AR handshake).
REQ-035 RD_DATA: RDATA/RID/RRESP/RLAST stable until RREADY; RLAST=1 only when counter is 0; handshake -> counter 0 ? IDLE : increment address, RD_ADDR (2 cycles per beat).
REQ-036 AWLEN/ARLEN 15 SHALL give exactly 16 beats; address wrap at top of RAM is silent.
Reset
REQ-037 RST SHALL force IDLE, last_wr=0, and AWREADY/WREADY/BVALID/ARREADY/RVALID/RLAST = 0, with BID/BRESP/RID/RRESP/RDATA = 0.
REQ-038 RST mid-burst SHALL abandon the transaction with no response; RAM contents are not reset or cleared.
Configuration
REQ-039 TAWAS_AXI_RAM_ERR_EN defined: AxADDR[31:ADDR_BITS+3] nonzero -> writes dropped, BRESP/RRESP=SLVERR (2'b10), RDATA=0; undefined: upper bits ignored, responses always OKAY (2'b00).
Structure
REQ-040 Package tawas_axi_pkg SHALL hold RESP_OKAY, RESP_SLVERR and the FSM state typedef; sub-module tawas_axi_ram_array holds the byte-enabled synchronous-read single-port RAM.
Verification
REQ-041 AW id=1 addr=0x10 len=0 and W 0x1122334455667788 strb=0xFF -> BVALID with BID=1 BRESP=0; then AR id=2 addr=0x10 -> RDATA=0x1122334455667788, RID=2, RLAST=1.
REQ-042 16-beat write from 0x0 (data=beat index), then ARLEN=15 read -> beats 0..15 in order, RLAST on beat 15 only.
REQ-043 Write 0xFF..FF then strb=0x0F data 0 to same word -> read returns 0xFFFFFFFF00000000.
REQ-044 AWVALID and ARVALID both asserted from reset -> write granted first, then read; BREADY held 0 for 5 cycles -> BVALID/BID stay stable.
REQ-045 With ERR_EN defined, write/read at 0x8000_0000 -> SLVERR on both, RAM unchanged; RST pulsed during a 4-beat read -> RVALID=0 next cycle and FSM in IDLE.
